// File: rtl/kbd_scancode_fifo_if.sv
// Receiver handshake plus memory-mapped read port of the keyboard scancode FIFO.
interface kbd_scancode_fifo_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ack;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic        overflow;

    modport slave (
        input  in_valid, in_data, rd_req, rd_sel,
        output in_ack, rd_data, empty, full, overflow
    );

    modport master (
        output in_valid, in_data, rd_req, rd_sel,
        input  in_ack, rd_data, empty, full, overflow
    );
endinterface

// File: rtl/kbd_scancode_fifo.sv
// PS/2 set-2 scancode FIFO with data/status read port.
// Define KBD_FIFO_PREFIX_DECODE_EN to fold E0/F0 prefixes into ext/brk tags.
module kbd_scancode_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               areset,
    kbd_scancode_fifo_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic          in_valid_q;
    logic          in_ack_q;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [9:0]    mem_q [DEPTH];

    logic       capture, push_req, push, pop, pop_req, stat_req, drop;
    logic       full_w, empty_w;
    logic [9:0] push_entry;
    logic [7:0] count8;

    // in_valid_q resets high so a level held through reset is not seen as an edge.
    assign capture  = bus.in_valid & ~in_valid_q;
    assign pop_req  = bus.rd_req & ~bus.rd_sel;
    assign stat_req = bus.rd_req & bus.rd_sel;
    assign full_w   = (count_q == CW'(DEPTH));
    assign empty_w  = (count_q == '0);
    assign pop      = pop_req & ~empty_w;
    assign push     = push_req & (~full_w | pop);
    assign drop     = push_req & full_w & ~pop;
    assign count8   = 8'(count_q);

`ifdef KBD_FIFO_PREFIX_DECODE_EN
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} pfx_state_e;
    pfx_state_e state_q, state_d;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (capture) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_data == 8'hE0)      state_d = EXT;
                    else if (bus.in_data == 8'hF0) state_d = BRK;
                end
                EXT:     state_d = (bus.in_data == 8'hF0) ? EXT_BRK : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A dropped entry still returns the FSM to IDLE, since state_d ignores fullness.
    always_comb begin
        push_req   = 1'b0;
        push_entry = {2'b00, bus.in_data};
        if (capture) begin
            case (state_q)
                IDLE:    push_req = (bus.in_data != 8'hE0) && (bus.in_data != 8'hF0);
                EXT: begin
                    push_req   = (bus.in_data != 8'hF0);
                    push_entry = {2'b10, bus.in_data};
                end
                BRK: begin
                    push_req   = 1'b1;
                    push_entry = {2'b01, bus.in_data};
                end
                default: begin
                    push_req   = 1'b1;
                    push_entry = {2'b11, bus.in_data};
                end
            endcase
        end
    end
`else
    assign push_req   = capture;
    assign push_entry = {2'b00, bus.in_data};
`endif

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        rd_data_d = rd_data_q;
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (stat_req) ovf_d = 1'b0;
        if (drop)     ovf_d = 1'b1;
        if (pop_req)
            rd_data_d = pop ? {1'b1, 21'b0, mem_q[head_q]} : 32'h0;
        else if (stat_req)
            rd_data_d = {16'h0, count8, 5'b0, ovf_q, full_w, empty_w};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            in_valid_q <= 1'b1;
            in_ack_q   <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            in_valid_q <= bus.in_valid;
            in_ack_q   <= capture;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= push_entry;
    end

    assign bus.in_ack   = in_ack_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_kbd_scancode_fifo.sv
// Scoreboard bench for kbd_scancode_fifo; expected words are queued as bytes are sent.
module tb_kbd_scancode_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    kbd_scancode_fifo_if bus_if();

    kbd_scancode_fifo #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic        m_ovf = 1'b0;
    logic [1:0]  m_pfx = 2'd0;   // 0 idle, 1 ext, 2 brk, 3 ext+brk

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0;
        m_pfx = 2'd0;
    endtask

    task automatic model_push(input logic [9:0] e);
        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back({1'b1, 21'b0, e});
    endtask

    task automatic model_byte(input logic [7:0] b);
`ifdef KBD_FIFO_PREFIX_DECODE_EN
        case (m_pfx)
            2'd0: begin
                if (b == 8'hE0)      m_pfx = 2'd1;
                else if (b == 8'hF0) m_pfx = 2'd2;
                else                 model_push({2'b00, b});
            end
            2'd1: begin
                if (b == 8'hF0) m_pfx = 2'd3;
                else begin model_push({2'b10, b}); m_pfx = 2'd0; end
            end
            2'd2: begin model_push({2'b01, b}); m_pfx = 2'd0; end
            default: begin model_push({2'b11, b}); m_pfx = 2'd0; end
        endcase
`else
        model_push({2'b00, b});
`endif
    endtask

    function automatic logic [31:0] model_pop();
        if (exp_q.size() == 0) return 32'h0;
        return exp_q.pop_front();
    endfunction

    function automatic logic [31:0] model_status();
        return {16'h0, 8'(exp_q.size()), 5'b0, m_ovf,
                exp_q.size() == DEPTH, exp_q.size() == 0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bus_if.in_data  = b;
        bus_if.in_valid = 1'b1;
        model_byte(b);
        tick();
        bus_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic sel, output logic [31:0] got);
        bus_if.rd_req = 1'b1;
        bus_if.rd_sel = sel;
        tick();
        got = bus_if.rd_data;
        bus_if.rd_req = 1'b0;
    endtask

    task automatic read_data(output logic [31:0] got, output logic [31:0] exp);
        exp = model_pop();
        bus_read(1'b0, got);
    endtask

    task automatic read_status(output logic [31:0] got, output logic [31:0] exp);
        exp   = model_status();
        m_ovf = 1'b0;
        bus_read(1'b1, got);
    endtask

    task automatic test_reset();
        logic [31:0] got;
        tick(); tick();
        n_tests++; if (bus_if.in_ack !== 1'b0) begin n_fail++; $display("FAIL reset_in_ack: got %b expected 0", bus_if.in_ack); end
        n_tests++; if (bus_if.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00000000", bus_if.rd_data); end
        n_tests++; if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus_if.empty); end
        n_tests++; if (bus_if.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus_if.full); end
        n_tests++; if (bus_if.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus_if.overflow); end
        areset = 1'b0;
        model_reset();
        tick();
        bus_read(1'b1, got);
        n_tests++; if (got !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h expected 00000001", got); end
    endtask

    task automatic test_single();
        logic [31:0] got, exp;
        bus_if.in_data  = 8'h1C;
        bus_if.in_valid = 1'b1;
        model_byte(8'h1C);
        n_tests++; if (bus_if.in_ack !== 1'b0) begin n_fail++; $display("FAIL ack_before_edge: got %b expected 0", bus_if.in_ack); end
        tick();
        n_tests++; if (bus_if.in_ack !== 1'b1) begin n_fail++; $display("FAIL ack_pulse: got %b expected 1", bus_if.in_ack); end
        n_tests++; if (bus_if.empty !== 1'b0) begin n_fail++; $display("FAIL empty_after_push: got %b expected 0", bus_if.empty); end
        tick();
        n_tests++; if (bus_if.in_ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle: got %b expected 0", bus_if.in_ack); end
        tick();
        bus_if.in_valid = 1'b0;
        tick();
        read_status(got, exp);
        n_tests++; if (got !== 32'h0000_0100 || got !== exp) begin n_fail++; $display("FAIL single_status: got %h expected 00000100", got); end
        read_data(got, exp);
        n_tests++; if (got !== 32'h8000_001C || got !== exp) begin n_fail++; $display("FAIL single_data: got %h expected 8000001c", got); end
        read_status(got, exp);
        n_tests++; if (got !== 32'h0000_0001 || got !== exp) begin n_fail++; $display("FAIL single_status_empty: got %h expected 00000001", got); end
    endtask

    task automatic test_prefix();
        logic [31:0] got, exp;
        logic [7:0]  bytes [5];
        int          n;
        bytes[0] = 8'hF0; bytes[1] = 8'h1C; bytes[2] = 8'hE0; bytes[3] = 8'hF0; bytes[4] = 8'h75;
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        n = exp_q.size();
        read_status(got, exp);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL prefix_status: got %h expected %h", got, exp); end
        for (int i = 0; i < n; i++) begin
            read_data(got, exp);
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL prefix_data_%0d: got %h expected %h", i, got, exp); end
        end
        n_tests++; if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL prefix_drained: got %b expected 1", bus_if.empty); end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i));
        n_tests++; if (bus_if.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", bus_if.full); end
        n_tests++; if (bus_if.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus_if.overflow); end
        read_status(got, exp);
        n_tests++; if (got !== 32'h0000_0806 || got !== exp) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000806", got); end
        read_status(got, exp);
        n_tests++; if (got !== 32'h0000_0802 || got !== exp) begin n_fail++; $display("FAIL ovf_status_cleared: got %h expected 00000802", got); end
        for (int i = 1; i <= DEPTH; i++) begin
            read_data(got, exp);
            n_tests++; if (got !== (32'h8000_0000 | 32'(i)) || got !== exp) begin n_fail++; $display("FAIL ovf_data_%0d: got %h expected %h", i, got, 32'h8000_0000 | 32'(i)); end
        end
    endtask

    task automatic test_empty_read();
        logic [31:0] got, exp;
        read_data(got, exp);
        n_tests++; if (got !== 32'h0 || got !== exp) begin n_fail++; $display("FAIL empty_read_data: got %h expected 00000000", got); end
        n_tests++; if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL empty_read_empty: got %b expected 1", bus_if.empty); end
        read_status(got, exp);
        n_tests++; if (got !== 32'h0000_0001 || got !== exp) begin n_fail++; $display("FAIL empty_read_status: got %h expected 00000001", got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i));
        bus_if.in_data  = 8'h2A;
        bus_if.in_valid = 1'b1;
        exp = model_pop();
        model_byte(8'h2A);
        bus_read(1'b0, got);
        bus_if.in_valid = 1'b0;
        n_tests++; if (got !== 32'h8000_0040 || got !== exp) begin n_fail++; $display("FAIL simul_pop_data: got %h expected 80000040", got); end
        tick();
        n_tests++; if (bus_if.full !== 1'b1) begin n_fail++; $display("FAIL simul_full: got %b expected 1", bus_if.full); end
        n_tests++; if (bus_if.overflow !== 1'b0) begin n_fail++; $display("FAIL simul_overflow: got %b expected 0", bus_if.overflow); end
        read_status(got, exp);
        n_tests++; if (got !== 32'h0000_0802 || got !== exp) begin n_fail++; $display("FAIL simul_status: got %h expected 00000802", got); end
        for (int i = 0; i < DEPTH; i++) begin
            read_data(got, exp);
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL simul_drain_%0d: got %h expected %h", i, got, exp); end
        end
        n_tests++; if (got !== 32'h8000_002A) begin n_fail++; $display("FAIL simul_last: got %h expected 8000002a", got); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] got, exp;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        bus_if.in_data  = 8'hF0;
        bus_if.in_valid = 1'b1;
        tick();
        areset = 1'b1;
        #1;
        n_tests++; if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL midreset_async_empty: got %b expected 1", bus_if.empty); end
        tick(); tick();
        areset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus_if.in_ack !== 1'b0 || bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL midreset_no_capture_%0d: got ack=%b empty=%b expected ack=0 empty=1", i, bus_if.in_ack, bus_if.empty); end
        end
        bus_if.in_valid = 1'b0;
        tick();
        send_byte(8'h1C);
        read_data(got, exp);
        n_tests++; if (got !== 32'h8000_001C || got !== exp) begin n_fail++; $display("FAIL midreset_data: got %h expected 8000001c", got); end
        n_tests++; if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL midreset_empty_end: got %b expected 1", bus_if.empty); end
    endtask

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        bus_if.rd_req   = 1'b0;
        bus_if.rd_sel   = 1'b0;
        test_reset();
        test_single();
        test_prefix();
        test_overflow();
        test_empty_read();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
